// File: rtl/wb_pkg.sv
// wb_pkg -- shared definitions for the Wishbone SRAM bank.
//   state_t : FSM state encoding (CLEAR only exists when WB_SRAM_CLEAR_EN is defined)
//   ww_of() : byte-offset width inside a data word, log2(DW)-3
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2
`ifdef WB_SRAM_CLEAR_EN
        , ST_CLEAR = 2'd3
`endif
    } state_t;

    function automatic int ww_of(input int dw);
        return $clog2(dw) - 3;
    endfunction

endpackage

// File: rtl/wb_sram_bytemem.sv
// wb_sram_bytemem -- single-port DW x 2^MW memory with per-byte write enables
// and a registered read port (read-before-write on the same address).
//   clk   : clock
//   en    : port enable; read data and writes only happen when high
//   we    : write enable
//   addr  : word address
//   sel   : byte-lane write enables
//   wdata : write data
//   rdata : registered read data
module wb_sram_bytemem #(
    parameter int MW = 10,
    parameter int DW = 32,
    parameter int SW = DW >> 3
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [MW-1:0] addr,
    input  logic [SW-1:0] sel,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    // One byte-wide array per lane so each lane maps onto its own RAM
    // column with an independent write enable.
    genvar gi;
    generate
        for (gi = 0; gi < SW; gi++) begin : g_lane
            logic [7:0] mem [0:(1<<MW)-1];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we && sel[gi]) begin
                        mem[addr] <= wdata[gi*8 +: 8];
                    end
                    q_reg <= mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/wb_sram_bank.sv
// wb_sram_bank -- Wishbone classic slave in front of a byte-lane SRAM.
// Optional feature: define WB_SRAM_CLEAR_EN to zero the whole memory after
// reset (one word per cycle, o_busy high, no requests accepted meanwhile).
// Ports:
//   clk, rst                            : clock, asynchronous active-high reset
//   i_wb_adr/sel/we/dat, i_wb_cyc/stb   : Wishbone request (byte address)
//   o_wb_dat, o_wb_ack, o_wb_err        : response; data is zero outside RESP
//   o_busy                              : FSM not in IDLE
module wb_sram_bank
    import wb_pkg::*;
#(
    parameter int MW = 10,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = DW >> 3,
    parameter int WS = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_wb_adr,
    input  logic [SW-1:0] i_wb_sel,
    input  logic          i_wb_we,
    input  logic [DW-1:0] i_wb_dat,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    output logic [DW-1:0] o_wb_dat,
    output logic          o_wb_ack,
    output logic          o_wb_err,
    output logic          o_busy
);

    localparam int WW = ww_of(DW);
    localparam int IW = MW + WW;
    localparam int XW = (AW > IW) ? AW : IW;
    localparam logic [3:0] WS_LAST = (WS > 0) ? 4'(WS - 1) : 4'd0;
`ifdef WB_SRAM_CLEAR_EN
    localparam state_t RST_STATE = ST_CLEAR;
`else
    localparam state_t RST_STATE = ST_IDLE;
`endif

    state_t        state_reg;
    logic [3:0]    wait_cnt_reg;
    logic [AW-1:0] adr_reg;
    logic [SW-1:0] sel_reg;
    logic          we_reg;
    logic [DW-1:0] dat_reg;
    logic          ack_reg;
    logic          err_reg;
`ifdef WB_SRAM_CLEAR_EN
    logic [MW-1:0] clr_cnt_reg;
`endif

    logic          req;
    logic          is_idle;
    logic          enter_resp;
    logic [AW-1:0] cur_adr;
    logic [SW-1:0] cur_sel;
    logic          cur_we;
    logic [DW-1:0] cur_dat;
    logic [XW-1:0] adr_wide;
    logic          oor;

    logic          mem_en;
    logic          mem_we;
    logic [MW-1:0] mem_addr;
    logic [SW-1:0] mem_sel;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    assign req     = i_wb_cyc & i_wb_stb;
    assign is_idle = (state_reg == ST_IDLE);

    // The memory access happens on the edge that enters RESP. With WS=0 that
    // is the accepting edge itself, so the live bus drives the memory in IDLE
    // and the latched copy drives it from WAIT.
    assign enter_resp = (is_idle && req && (WS == 0)) ||
                        ((state_reg == ST_WAIT) && i_wb_cyc && (wait_cnt_reg == WS_LAST));

    assign cur_adr  = is_idle ? i_wb_adr : adr_reg;
    assign cur_sel  = is_idle ? i_wb_sel : sel_reg;
    assign cur_we   = is_idle ? i_wb_we  : we_reg;
    assign cur_dat  = is_idle ? i_wb_dat : dat_reg;
    assign adr_wide = XW'(cur_adr);

    genvar gi;
    generate
        if (AW > IW) begin : g_oor
            assign oor = |cur_adr[AW-1:IW];
        end else begin : g_no_oor
            assign oor = 1'b0;
        end
        if (WW > 0) begin : g_byte_ofs
            logic unused_byte_ofs;
            assign unused_byte_ofs = ^adr_wide[WW-1:0];
        end
        if (XW > IW) begin : g_hi_bits
            logic unused_hi_bits;
            assign unused_hi_bits = ^adr_wide[XW-1:IW];
        end
    endgenerate

    always_comb begin
        mem_en    = enter_resp & ~oor;
        mem_we    = cur_we;
        mem_addr  = adr_wide[IW-1:WW];
        mem_sel   = cur_sel;
        mem_wdata = cur_dat;
`ifdef WB_SRAM_CLEAR_EN
        if (state_reg == ST_CLEAR) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_cnt_reg;
            mem_sel   = '1;
            mem_wdata = '0;
        end
`endif
        // No write may slip through while reset is held.
        mem_en = mem_en & ~rst;
    end

    wb_sram_bytemem #(
        .MW (MW),
        .DW (DW),
        .SW (SW)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .sel   (mem_sel),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RST_STATE;
            wait_cnt_reg <= 4'd0;
            adr_reg      <= '0;
            sel_reg      <= '0;
            we_reg       <= 1'b0;
            dat_reg      <= '0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
`ifdef WB_SRAM_CLEAR_EN
            clr_cnt_reg  <= '0;
`endif
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        adr_reg      <= i_wb_adr;
                        sel_reg      <= i_wb_sel;
                        we_reg       <= i_wb_we;
                        dat_reg      <= i_wb_dat;
                        wait_cnt_reg <= 4'd0;
                        if (WS == 0) begin
                            state_reg <= ST_RESP;
                            ack_reg   <= ~oor;
                            err_reg   <= oor;
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!i_wb_cyc) begin
                        state_reg <= ST_IDLE;
                    end else if (wait_cnt_reg == WS_LAST) begin
                        state_reg <= ST_RESP;
                        ack_reg   <= ~oor;
                        err_reg   <= oor;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
`ifdef WB_SRAM_CLEAR_EN
                ST_CLEAR: begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    if (&clr_cnt_reg) begin
                        state_reg <= ST_IDLE;
                    end
                end
`endif
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Read data is only presented during the ack cycle of a read.
    assign o_wb_dat = (ack_reg && !we_reg) ? mem_rdata : '0;
    assign o_wb_ack = ack_reg;
    assign o_wb_err = err_reg;
    assign o_busy   = ~is_idle;

endmodule
